// File: rtl/run_ctrl.sv
// Run sequencer for the single-cycle core: holds the core in reset while idle,
// issues a multi-cycle clear, runs until PC hits DONE_ADDR or the cycle budget expires.
module run_ctrl #(
    parameter int unsigned D         = 12,
    parameter int unsigned CW        = 16,
    parameter int unsigned DONE_ADDR = 128,
    parameter int unsigned TIMEOUT   = 16'hFFFF,
    parameter int unsigned RST_CYC   = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    input  logic [D-1:0]  prog_ctr,
    output logic          core_reset,
    output logic          run_en,
    output logic          busy,
    output logic          done,
    output logic          timeout,
    output logic [CW-1:0] cycle_count
);

    localparam int unsigned HW = $clog2(RST_CYC + 1);

    typedef enum logic [1:0] {IDLE, CLEAR, RUN, FIN} state_t;

    state_t        state;
    state_t        next_state;
    logic [HW-1:0] hold_cnt;
    logic [HW-1:0] hold_next;
    logic [CW-1:0] count_next;
    logic          timeout_next;
    logic [CW:0]   count_inc;

    // One extra bit so the TIMEOUT compare cannot alias on a wrapped count.
    assign count_inc = {1'b0, cycle_count} + (CW+1)'(1);

    always_comb begin
        next_state   = state;
        hold_next    = hold_cnt;
        count_next   = cycle_count;
        timeout_next = timeout;
        case (state)
            IDLE: begin
                if (req) begin
                    next_state   = CLEAR;
                    hold_next    = '0;
                    count_next   = '0;
                    timeout_next = 1'b0;
                end
            end
            CLEAR: begin
                if (!req) begin
                    next_state = IDLE;
                end else if (hold_cnt == HW'(RST_CYC - 1)) begin
                    next_state = RUN;
                end else begin
                    hold_next = hold_cnt + HW'(1);
                end
            end
            RUN: begin
                if (!req) begin
                    next_state = IDLE;
                end else begin
                    count_next = count_inc[CW-1:0];
                    if (prog_ctr == D'(DONE_ADDR)) begin
                        next_state   = FIN;
                        timeout_next = 1'b0;
                    end else if (count_inc == (CW+1)'(TIMEOUT)) begin
                        next_state   = FIN;
                        timeout_next = 1'b1;
                    end
                end
            end
            FIN: begin
                if (!req) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Outputs are decoded from next_state and registered so they never glitch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            hold_cnt    <= '0;
            cycle_count <= '0;
            timeout     <= 1'b0;
            core_reset  <= 1'b1;
            run_en      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= next_state;
            hold_cnt    <= hold_next;
            cycle_count <= count_next;
            timeout     <= timeout_next;
            core_reset  <= (next_state == IDLE) || (next_state == CLEAR);
            run_en      <= (next_state == RUN);
            busy        <= (next_state == CLEAR) || (next_state == RUN);
            done        <= (next_state == FIN);
        end
    end

endmodule

// File: tb/tb_run_ctrl.sv
// Self-checking bench for run_ctrl: directed runs from the test plan plus randomized
// runs, each checked against a per-run outcome computed from the completion/timeout rules.
module tb_run_ctrl;

    localparam int D    = 12;
    localparam int CW   = 16;
    localparam int DONE = 128;
    localparam int TO   = 50;
    localparam int RC   = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          req = 1'b0;
    logic [D-1:0]  prog_ctr = '0;
    logic          core_reset;
    logic          run_en;
    logic          busy;
    logic          done;
    logic          timeout;
    logic [CW-1:0] cycle_count;

    int checks = 0;
    int errors = 0;

    run_ctrl #(
        .D(D), .CW(CW), .DONE_ADDR(DONE), .TIMEOUT(TO), .RST_CYC(RC)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .prog_ctr(prog_ctr),
        .core_reset(core_reset), .run_en(run_en), .busy(busy), .done(done),
        .timeout(timeout), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_idle(input string tag, input int exp_cnt, input int exp_to);
        check_output({tag, "_core_reset"}, 32'(core_reset), 1);
        check_output({tag, "_run_en"}, 32'(run_en), 0);
        check_output({tag, "_busy"}, 32'(busy), 0);
        check_output({tag, "_done"}, 32'(done), 0);
        check_output({tag, "_timeout"}, 32'(timeout), 32'(exp_to));
        check_output({tag, "_count"}, 32'(cycle_count), 32'(exp_cnt));
    endtask

    function automatic logic [D-1:0] rand_pc();
        logic [D-1:0] v;
        v = D'($urandom_range(0, (1 << D) - 1));
        if (v == D'(DONE)) v = v + D'(1);
        return v;
    endfunction

    // n: RUN cycle on which PC shows DONE (0 = never); abort_k: RUN cycle on which req drops
    // (0 = never); fin_hold: extra cycles req stays high after done.
    task automatic apply_stimulus(input int n, input int abort_k, input int fin_hold);
        int  natural_end;
        bit  exp_to;
        bit  aborted;
        int  last_k;
        int  exp_cnt;
        natural_end = (n > 0 && n <= TO) ? n : TO;
        exp_to      = !(n > 0 && n <= TO);
        aborted     = (abort_k > 0) && (abort_k <= natural_end);
        last_k      = aborted ? abort_k : natural_end;
        exp_cnt     = aborted ? abort_k - 1 : natural_end;

        req      = 1'b1;
        prog_ctr = D'(DONE);
        for (int c = 0; c < RC; c++) begin
            @(negedge clk);
            check_output("clear_core_reset", 32'(core_reset), 1);
            check_output("clear_busy", 32'(busy), 1);
            check_output("clear_run_en", 32'(run_en), 0);
            check_output("clear_done", 32'(done), 0);
            check_output("clear_count", 32'(cycle_count), 0);
            check_output("clear_timeout", 32'(timeout), 0);
        end
        for (int k = 1; k <= last_k; k++) begin
            @(negedge clk);
            check_output("run_run_en", 32'(run_en), 1);
            check_output("run_core_reset", 32'(core_reset), 0);
            check_output("run_busy", 32'(busy), 1);
            check_output("run_done", 32'(done), 0);
            check_output("run_count", 32'(cycle_count), 32'(k - 1));
            prog_ctr = (k == n) ? D'(DONE) : rand_pc();
            if (k == abort_k) req = 1'b0;
        end
        @(negedge clk);
        if (aborted) begin
            check_idle("abort", exp_cnt, 0);
        end else begin
            check_output("fin_done", 32'(done), 1);
            check_output("fin_timeout", 32'(timeout), 32'(exp_to));
            check_output("fin_count", 32'(cycle_count), 32'(exp_cnt));
            check_output("fin_run_en", 32'(run_en), 0);
            check_output("fin_core_reset", 32'(core_reset), 0);
            check_output("fin_busy", 32'(busy), 0);
            for (int h = 0; h < fin_hold; h++) begin
                prog_ctr = ($urandom_range(0, 1) == 0) ? D'(DONE) : rand_pc();
                @(negedge clk);
                check_output("hold_done", 32'(done), 1);
                check_output("hold_count", 32'(cycle_count), 32'(exp_cnt));
                check_output("hold_run_en", 32'(run_en), 0);
            end
            req = 1'b0;
            @(negedge clk);
            check_idle("release", exp_cnt, 32'(exp_to));
        end
    endtask

    task automatic reset_mid_run(input int run_cycles);
        req      = 1'b1;
        prog_ctr = rand_pc();
        repeat (RC + run_cycles) @(negedge clk);
        check_output("prereset_run_en", 32'(run_en), 1);
        #2 reset = 1'b0;
        #1;
        check_idle("async_reset", 0, 0);
        @(negedge clk);
        req   = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check_idle("post_reset", 0, 0);
    endtask

    initial begin
        $display("[TB] run_ctrl bench start, TIMEOUT=%0d", TO);
        repeat (3) @(negedge clk);
        check_idle("reset", 0, 0);
        reset = 1'b1;
        @(negedge clk);
        check_idle("idle", 0, 0);

        apply_stimulus(40, 0, 10);
        apply_stimulus(0, 0, 2);
        apply_stimulus(TO, 0, 1);
        apply_stimulus(40, 7, 0);
        apply_stimulus(12, 0, 0);
        reset_mid_run(4);

        for (int r = 0; r < 20; r++) begin
            int n;
            int a;
            n = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 60));
            a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 60)) : 0;
            apply_stimulus(n, a, int'($urandom_range(0, 4)));
        end
        reset_mid_run(int'($urandom_range(1, 20)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
